// File: rtl/step_counter.sv
// step_counter: modulo-MODULUS counter that steps by STEP up or down per enabled
// cycle, either wrapping or clamping at the ends (SATURATE). A parallel load with
// range check is provided. wrap and load_err are one-cycle event pulses for the
// downstream bit-accounting logic.
module step_counter #(
  parameter int WIDTH    = 3,
  parameter int STEP     = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit,
  output logic             load_err
);

  // Constants carried in WIDTH+1 bits so count+STEP and MODULUS itself
  // (which may equal 2**WIDTH) are represented without truncation.
  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LIMIT   = WIDTH'(MODULUS - 1);

  // Parameter legality is enforced at elaboration; a bad combination
  // would silently produce counts outside 0..MODULUS-1.
  generate
    if (STEP < 1 || STEP >= MODULUS) begin : g_bad_step
      $error("step_counter: STEP=%0d must satisfy 1 <= STEP < MODULUS=%0d", STEP, MODULUS);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("step_counter: MODULUS=%0d must satisfy 2 <= MODULUS <= 2**WIDTH (WIDTH=%0d)",
             MODULUS, WIDTH);
    end
  endgenerate

  // Upward step. Result packs {event_flag, next_count}; the flag marks
  // a wrap (SATURATE=0) or a clamp at MODULUS-1 (SATURATE=1).
  function automatic logic [WIDTH:0] step_up_f(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] s;
    s = {1'b0, c} + STEP_X;
    if (s >= MOD_X) begin
      if (SATURATE != 0) begin
        return {1'b1, LIMIT};
      end
      return {1'b1, WIDTH'(s - MOD_X)};
    end
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  // Downward step, same packing. Underflow is detected before subtracting
  // so the arithmetic never goes negative; c+MODULUS-STEP stays below MODULUS.
  function automatic logic [WIDTH:0] step_dn_f(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] cx;
    cx = {1'b0, c};
    if (cx < STEP_X) begin
      if (SATURATE != 0) begin
        return {1'b1, {WIDTH{1'b0}}};
      end
      return {1'b1, WIDTH'(cx + MOD_X - STEP_X)};
    end
    return {1'b0, WIDTH'(cx - STEP_X)};
  endfunction

  // Range check for a parallel load.
  function automatic logic load_bad_f(input logic [WIDTH-1:0] d);
    return ({1'b0, d} >= MOD_X);
  endfunction

  logic [WIDTH:0] step_next;

  // Candidate next value and event flag for an enabled step in the current direction.
  always_comb begin
    step_next = up ? step_up_f(count) : step_dn_f(count);
  end

  // Count register and event pulses; priority reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (load_bad_f(data)) begin
        count    <= '0;
        load_err <= 1'b1;
      end else begin
        count    <= data;
        load_err <= 1'b0;
      end
    end else if (en) begin
      count    <= step_next[WIDTH-1:0];
      wrap     <= step_next[WIDTH];
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

  // Limit in the current direction, combinational on count and up.
  assign at_limit = up ? (count == LIMIT) : (count == '0);

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: drives three step_counter configurations (defaults,
// MODULUS=10/WIDTH=4, saturating) from shared stimulus; expected responses
// from an arithmetic reference model are queued and checked by a monitor.
module tb_step_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] data  = '0;

  logic [2:0] cnt0, cnt2;
  logic [3:0] cnt1;
  logic       wrap0, wrap1, wrap2;
  logic       lim0, lim1, lim2;
  logic       lerr0, lerr1, lerr2;

  step_counter #(.WIDTH(3), .STEP(3), .MODULUS(8), .SATURATE(0)) u_dflt (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .data(data[2:0]),
    .count(cnt0), .wrap(wrap0), .at_limit(lim0), .load_err(lerr0));

  step_counter #(.WIDTH(4), .STEP(3), .MODULUS(10), .SATURATE(0)) u_m10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .data(data),
    .count(cnt1), .wrap(wrap1), .at_limit(lim1), .load_err(lerr1));

  step_counter #(.WIDTH(3), .STEP(3), .MODULUS(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .data(data[2:0]),
    .count(cnt2), .wrap(wrap2), .at_limit(lim2), .load_err(lerr2));

  typedef struct {
    int c;
    bit w;
    bit le;
    bit al;
  } exp_t;

  exp_t q[$];
  int   wid    [3] = '{3, 4, 3};
  int   mod_n  [3] = '{8, 10, 8};
  int   step_n [3] = '{3, 3, 3};
  bit   sat    [3] = '{1'b0, 1'b0, 1'b1};
  int   mc     [3] = '{0, 0, 0};
  int   nchk = 0;
  int   nfail = 0;

  function automatic void chk(string nm, logic [31:0] act, int exp);
    nchk++;
    if (act !== 32'(exp)) begin
      nfail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endfunction

  // Apply one cycle of stimulus and queue what each instance must show after the edge.
  task automatic drive(bit r, bit l, bit e, bit u, int d);
    @(negedge clk);
    reset = r; load = l; en = e; up = u; data = 4'(d);
    for (int i = 0; i < 3; i++) begin
      exp_t x;
      int   dd;
      int   t;
      dd   = d % (1 << wid[i]);
      x.w  = 1'b0;
      x.le = 1'b0;
      if (r) begin
        mc[i] = 0;
      end else if (l) begin
        if (dd >= mod_n[i]) begin
          mc[i] = 0;
          x.le  = 1'b1;
        end else begin
          mc[i] = dd;
        end
      end else if (e) begin
        t = mc[i] + (u ? step_n[i] : -step_n[i]);
        if (t < 0 || t >= mod_n[i]) x.w = 1'b1;
        if (sat[i]) mc[i] = (t < 0) ? 0 : ((t >= mod_n[i]) ? mod_n[i] - 1 : t);
        else        mc[i] = (t + mod_n[i]) % mod_n[i];
      end
      x.c  = mc[i];
      x.al = u ? (mc[i] == mod_n[i] - 1) : (mc[i] == 0);
      q.push_back(x);
    end
  endtask

  // Monitor: after each edge, pop one expectation per instance and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() >= 3) begin
        exp_t x;
        x = q.pop_front();
        chk("dflt.count", 32'(cnt0), x.c);  chk("dflt.wrap", 32'(wrap0), int'(x.w));
        chk("dflt.load_err", 32'(lerr0), int'(x.le)); chk("dflt.at_limit", 32'(lim0), int'(x.al));
        x = q.pop_front();
        chk("m10.count", 32'(cnt1), x.c);   chk("m10.wrap", 32'(wrap1), int'(x.w));
        chk("m10.load_err", 32'(lerr1), int'(x.le));  chk("m10.at_limit", 32'(lim1), int'(x.al));
        x = q.pop_front();
        chk("sat.count", 32'(cnt2), x.c);   chk("sat.wrap", 32'(wrap2), int'(x.w));
        chk("sat.load_err", 32'(lerr2), int'(x.le));  chk("sat.at_limit", 32'(lim2), int'(x.al));
      end
    end
  end

  initial begin
    // reset state
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    // full upward cycle
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 1, 0);
    // load 4 then step down
    drive(0, 1, 0, 0, 4);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);
    // load 9 then up; out-of-range load 12; pulse must drop
    drive(0, 1, 0, 1, 9);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0);
    drive(0, 1, 0, 1, 12);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    // saturating run from 0: up into the clamp, then down into the clamp
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0);
    // simultaneous reset+load+en, then load+en
    drive(0, 1, 0, 1, 6);
    drive(1, 1, 1, 1, 5);
    drive(0, 1, 1, 1, 5);
    drive(0, 1, 1, 0, 2);
    // hold mid-sequence with at_limit following up at 7 and at 0
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)));
    end
    drive(0, 0, 0, 1, 0);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
